fp_divsqrt_pool: RTL

Parametrised allocator and lifecycle tracker for a pool of `NUM_UNITS` iterative FP divide/sqrt units. It sits between the issue stage and the iterative units, and is the multi-channel successor of the single-width divider phase tracker. It adds the following over the previous tracker:
- round-robin allocation with an allocated-unit index;
- per-unit active-list tagging;
- wrap-around selective flush;
- optional result capture.

---
 rtl/fp_divsqrt_pool_if.sv | 45 ++++
 rtl/fp_divsqrt_pool.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fp_divsqrt_pool_if.sv
// Issue/unit-side bundle for fp_divsqrt_pool. 'release' is a reserved word,
// so the per-unit release strobe is carried as unit_release.
interface fp_divsqrt_pool_if #(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned AL_W      = 6,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                        acq_req;
  logic [AL_W-1:0]             acq_al_ptr;
  logic                        acq_grant;
  logic [IDX_W-1:0]            acq_idx;
  logic [NUM_UNITS-1:0]        start;
  logic [NUM_UNITS-1:0]        unit_start;
  logic [NUM_UNITS-1:0]        unit_kill;
  logic [NUM_UNITS-1:0]        unit_done;
  logic [NUM_UNITS*DATA_W-1:0] unit_result;
  logic [NUM_UNITS*5-1:0]      unit_fflags;
  logic [NUM_UNITS-1:0]        unit_release;
  logic [NUM_UNITS-1:0]        free;
  logic [NUM_UNITS-1:0]        reserved;
  logic [NUM_UNITS-1:0]        busy;
  logic [NUM_UNITS-1:0]        finished;
  logic [NUM_UNITS*DATA_W-1:0] result_o;
  logic [NUM_UNITS*5-1:0]      fflags_o;
  logic                        flush_valid;
  logic                        flush_all;
  logic [AL_W-1:0]             flush_head;
  logic [AL_W-1:0]             flush_tail;

  modport master (
    output acq_req, acq_al_ptr, start, unit_done, unit_result, unit_fflags,
           unit_release, flush_valid, flush_all, flush_head, flush_tail,
    input  acq_grant, acq_idx, unit_start, unit_kill, free, reserved, busy,
           finished, result_o, fflags_o
  );

  modport slave (
    input  acq_req, acq_al_ptr, start, unit_done, unit_result, unit_fflags,
           unit_release, flush_valid, flush_all, flush_head, flush_tail,
    output acq_grant, acq_idx, unit_start, unit_kill, free, reserved, busy,
           finished, result_o, fflags_o
  );
endinterface

// File: rtl/fp_divsqrt_pool.sv
// Round-robin allocator and phase tracker for a pool of iterative FP div/sqrt units.
// Define FP_DIVSQRT_POOL_RESULT_BUF_EN to register results/flags on unit_done.
module fp_divsqrt_pool #(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned AL_W      = 6,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_divsqrt_pool_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {
    PH_FREE,
    PH_RESERVED,
    PH_PROCESSING,
    PH_WAITING
  } phase_e;

  phase_e               phase_q [NUM_UNITS];
  phase_e               phase_d [NUM_UNITS];
  logic [AL_W-1:0]      tag_q   [NUM_UNITS];
  logic [AL_W-1:0]      tag_d   [NUM_UNITS];
  logic [IDX_W-1:0]     rr_q, rr_d;

  logic                 found, grant;
  logic [IDX_W-1:0]     cand, pick, gidx;
  logic [NUM_UNITS-1:0] match, ustart, kill, free_nxt;
  logic [NUM_UNITS-1:0] reserved, busy, finished;

  logic [NUM_UNITS*DATA_W-1:0] res_flat;
  logic [NUM_UNITS*5-1:0]      flg_flat;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand = IDX_W'((32'(rr_q) + k) % NUM_UNITS);
      if (!found && phase_q[cand] == PH_FREE) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    grant = found & bus.acq_req & ~bus.flush_valid & rst_n;
    gidx  = grant ? pick : '0;
    rr_d  = grant ? IDX_W'((32'(pick) + 1) % NUM_UNITS) : rr_q;
  end

  always_comb begin
    match    = '0;
    ustart   = '0;
    kill     = '0;
    free_nxt = '0;
    reserved = '0;
    busy     = '0;
    finished = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      phase_d[i] = phase_q[i];
      tag_d[i]   = tag_q[i];
      // Flush range is [head, tail) on a circular active list; head==tail is empty.
      if (phase_q[i] != PH_FREE && bus.flush_valid) begin
        if (bus.flush_all)
          match[i] = 1'b1;
        else if (bus.flush_head < bus.flush_tail)
          match[i] = (tag_q[i] >= bus.flush_head) && (tag_q[i] < bus.flush_tail);
        else if (bus.flush_head > bus.flush_tail)
          match[i] = (tag_q[i] >= bus.flush_head) || (tag_q[i] < bus.flush_tail);
      end
      if (match[i]) begin
        phase_d[i] = PH_FREE;
        kill[i]    = 1'b1;
      end else begin
        case (phase_q[i])
          PH_FREE: begin
            if (grant && gidx == IDX_W'(i)) begin
              phase_d[i] = PH_RESERVED;
              tag_d[i]   = bus.acq_al_ptr;
            end
          end
          PH_RESERVED: begin
            if (bus.start[i]) begin
              ustart[i]  = 1'b1;
              phase_d[i] = PH_PROCESSING;
            end
          end
          PH_PROCESSING: if (bus.unit_done[i])    phase_d[i] = PH_WAITING;
          PH_WAITING:    if (bus.unit_release[i]) phase_d[i] = PH_FREE;
          default: ;
        endcase
      end
      free_nxt[i] = (phase_d[i] == PH_FREE);
      reserved[i] = (phase_q[i] == PH_RESERVED);
      busy[i]     = (phase_q[i] == PH_PROCESSING);
      finished[i] = (phase_q[i] == PH_WAITING);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        phase_q[i] <= PH_FREE;
        tag_q[i]   <= '0;
      end
      rr_q <= '0;
    end else begin
      phase_q <= phase_d;
      tag_q   <= tag_d;
      rr_q    <= rr_d;
    end
  end

`ifdef FP_DIVSQRT_POOL_RESULT_BUF_EN
  logic [DATA_W-1:0] res_q [NUM_UNITS];
  logic [DATA_W-1:0] res_d [NUM_UNITS];
  logic [4:0]        flg_q [NUM_UNITS];
  logic [4:0]        flg_d [NUM_UNITS];

  always_comb begin
    res_flat = '0;
    flg_flat = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      res_d[i] = res_q[i];
      flg_d[i] = flg_q[i];
      if (match[i]) begin
        res_d[i] = '0;
        flg_d[i] = '0;
      end else if (phase_q[i] == PH_PROCESSING && bus.unit_done[i]) begin
        res_d[i] = bus.unit_result[i*DATA_W +: DATA_W];
        flg_d[i] = bus.unit_fflags[i*5 +: 5];
      end
      res_flat[i*DATA_W +: DATA_W] = res_q[i];
      flg_flat[i*5 +: 5]           = flg_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end
`else
  assign res_flat = rst_n ? bus.unit_result : '0;
  assign flg_flat = rst_n ? bus.unit_fflags : '0;
`endif

  // Reset forces the pool-wide view: everything free, every unit aborted.
  assign bus.acq_grant  = grant;
  assign bus.acq_idx    = gidx;
  assign bus.unit_start = rst_n ? ustart   : '0;
  assign bus.unit_kill  = rst_n ? kill     : '1;
  assign bus.free       = rst_n ? free_nxt : '1;
  assign bus.reserved   = reserved;
  assign bus.busy       = busy;
  assign bus.finished   = finished;
  assign bus.result_o   = res_flat;
  assign bus.fflags_o   = flg_flat;

endmodule
